// File: rtl/stoper_ctrl.sv
// Stopwatch command sequencer: debounces four buttons, decodes one-hot rising edges into
// clear/pause/up/down commands and drives the ticker controls and status LEDs from a small FSM.
module stoper_ctrl #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       end_reached,
    output logic       tick_reset,
    output logic       tick_stop,
    output logic       tick_count_up,
    output logic [2:0] led
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_UP,
        S_RUN_DOWN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_lvl;
    logic [3:0]       r_lvl_q;

    state_t           r_state;
    logic             r_dir;
    logic             r_tick_reset;
    logic             r_tick_stop;
    logic             r_tick_count_up;
    logic [2:0]       r_led;

    logic [3:0]       w_cmd;
    state_t           w_nxt_state;
    logic             w_nxt_dir;
    logic             w_nxt_clr;
    logic             w_nxt_run;
    logic [2:0]       w_nxt_led;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_lvl   <= '0;
            r_lvl_q <= '0;
        end else begin
            r_lvl_q <= r_lvl;
            for (int i = 0; i < 4; i++) begin
                if (btn[i] != r_lvl[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_lvl[i] <= btn[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // An edge counts only when it is the sole held button, so a one-hot level with any rise.
    assign w_cmd = ($onehot(r_lvl) && ((r_lvl & ~r_lvl_q) != 4'b0000)) ? r_lvl : 4'b0000;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dir   = r_dir;
        w_nxt_clr   = 1'b0;
        if (w_cmd[3]) begin
            w_nxt_state = S_IDLE;
            w_nxt_dir   = 1'b1;
            w_nxt_clr   = 1'b1;
        end else if (w_cmd[1]) begin
            w_nxt_state = S_RUN_UP;
            w_nxt_dir   = 1'b1;
        end else if (w_cmd[0]) begin
            w_nxt_state = S_RUN_DOWN;
            w_nxt_dir   = 1'b0;
        end else if (w_cmd[2]) begin
            case (r_state)
                S_RUN_UP, S_RUN_DOWN: w_nxt_state = S_PAUSED;
                S_PAUSED:             w_nxt_state = r_dir ? S_RUN_UP : S_RUN_DOWN;
                default:              w_nxt_state = r_state;
            endcase
        end else if (end_reached && (r_state == S_RUN_UP || r_state == S_RUN_DOWN)) begin
            w_nxt_state = S_DONE;
        end

        w_nxt_run = (w_nxt_state == S_RUN_UP) || (w_nxt_state == S_RUN_DOWN);
        case (w_nxt_state)
            S_RUN_UP:   w_nxt_led = 3'b010;
            S_RUN_DOWN: w_nxt_led = 3'b001;
            S_DONE:     w_nxt_led = 3'b100;
            default:    w_nxt_led = 3'b000;
        endcase
    end

    // tick_reset is held high through reset so the ticker clears alongside us.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_dir           <= 1'b1;
            r_tick_reset    <= 1'b1;
            r_tick_stop     <= 1'b1;
            r_tick_count_up <= 1'b1;
            r_led           <= 3'b000;
        end else begin
            r_state         <= w_nxt_state;
            r_dir           <= w_nxt_dir;
            r_tick_reset    <= w_nxt_clr;
            r_tick_stop     <= ~w_nxt_run;
            r_tick_count_up <= w_nxt_dir;
            r_led           <= w_nxt_led;
        end
    end

    assign tick_reset    = r_tick_reset;
    assign tick_stop     = r_tick_stop;
    assign tick_count_up = r_tick_count_up;
    assign led           = r_led;

endmodule

// File: tb/tb_stoper_ctrl.sv
// Bench for stoper_ctrl: directed scenarios then random button/end_reached traffic,
// every cycle compared against a history-based reference model of the stopwatch rules.
module tb_stoper_ctrl;

    localparam int D = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_PAUS = 3;
    localparam int M_DONE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       end_reached = 1'b0;
    logic       tick_reset;
    logic       tick_stop;
    logic       tick_count_up;
    logic [2:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_st;
    logic       m_dir;
    logic [3:0] m_lvl;
    logic [3:0] m_prev;
    logic [3:0] hist[$];
    logic       e_reset, e_stop, e_up;
    logic [2:0] e_led;

    stoper_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .end_reached   (end_reached),
        .tick_reset    (tick_reset),
        .tick_stop     (tick_stop),
        .tick_count_up (tick_count_up),
        .led           (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock edge of the specification's behaviour, using inputs present at the edge.
    task automatic model_step();
        int   cmd;
        bit   all_diff;
        logic [3:0] rise;
        if (reset) begin
            m_st = M_IDLE; m_dir = 1'b1; m_lvl = '0; m_prev = '0;
            hist.delete();
            e_reset = 1'b1; e_stop = 1'b1; e_up = 1'b1; e_led = 3'b000;
        end else begin
            rise = m_lvl & ~m_prev;
            cmd  = -1;
            if ($countones(m_lvl) == 1 && rise != 0)
                for (int b = 0; b < 4; b++) if (rise[b]) cmd = b;
            e_reset = 1'b0;
            case (cmd)
                3: begin m_st = M_IDLE; m_dir = 1'b1; e_reset = 1'b1; end
                1: begin m_st = M_UP;   m_dir = 1'b1; end
                0: begin m_st = M_DOWN; m_dir = 1'b0; end
                2: begin
                    if (m_st == M_UP || m_st == M_DOWN) m_st = M_PAUS;
                    else if (m_st == M_PAUS) m_st = m_dir ? M_UP : M_DOWN;
                end
                default: if (end_reached && (m_st == M_UP || m_st == M_DOWN)) m_st = M_DONE;
            endcase
            e_stop = !(m_st == M_UP || m_st == M_DOWN);
            e_up   = m_dir;
            e_led  = (m_st == M_UP) ? 3'b010 : (m_st == M_DOWN) ? 3'b001 :
                     (m_st == M_DONE) ? 3'b100 : 3'b000;
            m_prev = m_lvl;
            hist.push_back(btn);
            if (hist.size() > D) void'(hist.pop_front());
            // A level flips once the last D raw samples all disagree with it.
            if (hist.size() == D) begin
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_lvl[b]) all_diff = 1'b0;
                    if (all_diff) m_lvl[b] = btn[b];
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("tick_reset", tick_reset, e_reset);
        chk("tick_stop", tick_stop, e_stop);
        chk("tick_count_up", tick_count_up, e_up);
        chk("led", led, e_led);
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        btn = b;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_tick_reset_hi", tick_reset, 1);
        reset = 1'b0;
        cyc();
        chk("post_rst_tick_reset", tick_reset, 0);
        chk("post_rst_stop", tick_stop, 1);
        chk("post_rst_up", tick_count_up, 1);
        chk("post_rst_led", led, 3'b000);

        // UP accepted on the fifth edge after the rise
        hold(4'b0010, 4);
        chk("up_not_yet", led, 3'b000);
        hold(4'b0010, 1);
        chk("up_led", led, 3'b010);
        chk("up_stop", tick_stop, 0);
        hold(4'b0010, 5);
        hold(4'b0000, 6);
        hold(4'b0010, 2);
        hold(4'b0000, 6);
        chk("glitch_led", led, 3'b010);

        hold(4'b0100, 6); hold(4'b0000, 6);
        chk("pause_stop", tick_stop, 1);
        chk("pause_led", led, 3'b000);
        hold(4'b0100, 6); hold(4'b0000, 6);
        chk("resume_led", led, 3'b010);
        chk("resume_up", tick_count_up, 1);

        hold(4'b0001, 6); hold(4'b0000, 6);
        hold(4'b0100, 6); hold(4'b0000, 6);
        hold(4'b0100, 6); hold(4'b0000, 6);
        chk("resume_down_up", tick_count_up, 0);
        chk("resume_down_led", led, 3'b001);

        end_reached = 1'b1; cyc(); end_reached = 1'b0;
        chk("done_led", led, 3'b100);
        chk("done_stop", tick_stop, 1);
        hold(4'b0100, 6); hold(4'b0000, 6);
        chk("done_pause_led", led, 3'b100);

        // CLEAR seen in the same cycle as end_reached while running up
        hold(4'b0010, 6); hold(4'b0000, 6);
        hold(4'b1000, 4);
        end_reached = 1'b1; cyc(); end_reached = 1'b0;
        chk("clr_pulse", tick_reset, 1);
        chk("clr_led", led, 3'b000);
        cyc();
        chk("clr_pulse_end", tick_reset, 0);
        hold(4'b0000, 6);

        hold(4'b0011, 8);
        chk("dual_led", led, 3'b000);
        hold(4'b0010, 8);
        chk("dual_rel_led", led, 3'b000);
        chk("dual_rel_stop", tick_stop, 1);
        hold(4'b0000, 6);

        for (int s = 0; s < 400; s++) begin
            int r;
            int len;
            logic [3:0] pat;
            r = $urandom_range(0, 19);
            if (r < 10)      pat = 4'b0001 << $urandom_range(0, 3);
            else if (r < 15) pat = 4'b0000;
            else             pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            btn = pat;
            for (int i = 0; i < len; i++) begin
                end_reached = ($urandom_range(0, 5) == 0);
                reset = ($urandom_range(0, 199) == 0);
                cyc();
            end
            reset = 1'b0;
            end_reached = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
